// File: rtl/led_ser_pkg.sv
// Shared definitions for the LED serial driver: FSM state encoding and
// default frame geometry.
package led_ser_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } led_ser_state_t;

  localparam int LED_SER_WIDTH   = 16;
  localparam int LED_SER_CLK_DIV = 4;

endpackage

// File: rtl/led_ser_tick.sv
// Clearable divider for the LED serial driver. Counts 0..CLK_DIV-1 while
// enabled and flags the last count of each sclk half-period with tick.
// The FSM clears it on every state change so each state lasts exactly
// CLK_DIV cycles.
module led_ser_tick
  import led_ser_pkg::*;
#(
  parameter int CLK_DIV = LED_SER_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DIV_MAX);

  // Half-period counter; wraps on tick, parks at 0 when idle or cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || !en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_serial_driver.sv
// Serialises the LED bar vector into a 74HC595-style chain (sclk/sdata/latch).
// A frame is sent once after reset and then only when the vector differs
// from the last latched value; frames always run to completion.
// Optional macro LED_SER_OE_EN adds oe_n, held high until the first frame
// after reset has been latched so power-up garbage is never displayed.
module led_serial_driver
  import led_ser_pkg::*;
#(
  parameter int WIDTH   = LED_SER_WIDTH,
  parameter int CLK_DIV = LED_SER_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] led,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             busy
`ifdef LED_SER_OE_EN
  ,
  output logic             oe_n
`endif
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);

  led_ser_state_t   state;
  led_ser_state_t   state_next;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] last_sent;
  logic [BW-1:0]    bit_cnt;
  logic             init_pend;
  logic             tick;
  logic             clr;
  logic             start;
  logic             shift_next;
  logic             done;

  led_ser_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (state != IDLE),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the one-cycle events that steer the datapath.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift_next = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (init_pend || (led != last_sent)) begin
          start      = 1'b1;
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt == '0) begin
            state_next = LATCH;
          end else begin
            shift_next = 1'b1;
            state_next = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    clr = (state_next != state);
  end

  // Registered link outputs and frame bookkeeping. sclk/latch/busy are
  // decoded from the next state so they line up with the state register
  // without a combinational path to the pins. sdata only moves on the
  // sclk falling edge, keeping it stable across every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      latch     <= 1'b0;
      busy      <= 1'b0;
      shadow    <= '0;
      last_sent <= '0;
      bit_cnt   <= '0;
      init_pend <= 1'b1;
    end else begin
      sclk  <= (state_next == SHIFT_HI);
      latch <= (state_next == LATCH);
      busy  <= (state_next != IDLE);
      if (start) begin
        shadow    <= led;
        bit_cnt   <= BIT_MAX;
        sdata     <= led[WIDTH-1];
        init_pend <= 1'b0;
      end
      if (shift_next) begin
        bit_cnt <= bit_cnt - 1'b1;
        sdata   <= shadow[bit_cnt - 1'b1];
      end
      if (done) begin
        last_sent <= shadow;
        sdata     <= 1'b0;
      end
    end
  end

`ifdef LED_SER_OE_EN
  // Output enable stays off until the first post-reset frame is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_n <= 1'b1;
    end else if (done) begin
      oe_n <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_led_serial_driver.sv
// Directed bench for led_serial_driver: a 16-bit/CLK_DIV=4 instance and a
// 4-bit/CLK_DIV=1 instance. A behavioural 74HC595 model (shift on sclk
// rise, copy on latch rise) observes each link.
module tb_led_serial_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] led = 16'h0000;
  logic        sclk, sdata, latch, busy;
  logic [3:0]  led_s = 4'h0;
  logic        sclk_s, sdata_s, latch_s, busy_s;
`ifdef LED_SER_OE_EN
  logic        oe_n, oe_n_s;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_serial_driver #(.WIDTH(16), .CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .led   (led),
    .sclk  (sclk),
    .sdata (sdata),
    .latch (latch),
    .busy  (busy)
`ifdef LED_SER_OE_EN
    , .oe_n (oe_n)
`endif
  );

  led_serial_driver #(.WIDTH(4), .CLK_DIV(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .led   (led_s),
    .sclk  (sclk_s),
    .sdata (sdata_s),
    .latch (latch_s),
    .busy  (busy_s)
`ifdef LED_SER_OE_EN
    , .oe_n (oe_n_s)
`endif
  );

  // Chip model and cycle counters for the 16-bit link.
  logic        sclk_q = 1'b0, sdata_q = 1'b0, latch_q = 1'b0;
  logic [15:0] rx = '0, latched = '0;
  int rises = 0, frames = 0, lat_cyc = 0, busy_cyc = 0, stab_err = 0;
  always @(negedge clk) begin
    if (sclk && !sclk_q) begin
      rx    <= {rx[14:0], sdata};
      rises <= rises + 1;
      if (sdata !== sdata_q) stab_err <= stab_err + 1;
    end
    if (latch && !latch_q) begin
      latched <= rx;
      frames  <= frames + 1;
    end
    if (latch) lat_cyc  <= lat_cyc + 1;
    if (busy)  busy_cyc <= busy_cyc + 1;
    sclk_q  <= sclk;
    sdata_q <= sdata;
    latch_q <= latch;
  end

  // Chip model and cycle counters for the 4-bit link.
  logic       sclk_sq = 1'b0, sdata_sq = 1'b0, latch_sq = 1'b0;
  logic [3:0] rx_s = '0, latched_s = '0;
  int rises_s = 0, frames_s = 0, lat_cyc_s = 0, busy_cyc_s = 0, hi_cyc_s = 0, stab_err_s = 0;
  always @(negedge clk) begin
    if (sclk_s && !sclk_sq) begin
      rx_s    <= {rx_s[2:0], sdata_s};
      rises_s <= rises_s + 1;
      if (sdata_s !== sdata_sq) stab_err_s <= stab_err_s + 1;
    end
    if (latch_s && !latch_sq) begin
      latched_s <= rx_s;
      frames_s  <= frames_s + 1;
    end
    if (latch_s) lat_cyc_s  <= lat_cyc_s + 1;
    if (busy_s)  busy_cyc_s <= busy_cyc_s + 1;
    if (sclk_s)  hi_cyc_s   <= hi_cyc_s + 1;
    sclk_sq  <= sclk_s;
    sdata_sq <= sdata_s;
    latch_sq <= latch_s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  int b_rises, b_frames, b_lat, b_busy, b_rises_s, b_frames_s, b_lat_s, b_busy_s, b_hi_s;

  initial begin
    // Reset state.
    repeat (3) step();
    chk("rst_outputs", {28'd0, sclk, sdata, latch, busy}, 32'd0);
    chk("rst_outputs_s", {28'd0, sclk_s, sdata_s, latch_s, busy_s}, 32'd0);
`ifdef LED_SER_OE_EN
    chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
`endif

    // Init frame of zeros after release.
    rst_n = 1'b1;
    step();
    chk("init_busy", {31'd0, busy}, 32'd1);
    chk("init_sdata", {31'd0, sdata}, 32'd0);
    wait_idle("init");
    chk("init_rises", rises, 32'd16);
    chk("init_latch_cycles", lat_cyc, 32'd4);
    chk("init_busy_cycles", busy_cyc, 32'd132);
    chk("init_frames", frames, 32'd1);
    chk("init_word", {16'd0, latched}, 32'h0000);
    chk("init_frames_s", frames_s, 32'd1);
    chk("init_word_s", {28'd0, latched_s}, 32'h0);
`ifdef LED_SER_OE_EN
    chk("oe_n_after_init", {31'd0, oe_n}, 32'd0);
`endif
    repeat (40) step();
    chk("init_no_refire", frames, 32'd1);

    // Single value 0x001F, MSB first, with first-rise latency.
    b_frames = frames;
    led = 16'h001F;
    step();
    chk("f1f_busy", {31'd0, busy}, 32'd1);
    repeat (3) step();
    chk("f1f_sclk_low", {31'd0, sclk}, 32'd0);
    step();
    chk("f1f_sclk_rise", {31'd0, sclk}, 32'd1);
    wait_idle("f1f");
    chk("f1f_shift_reg", {16'd0, rx}, 32'h001F);
    chk("f1f_word", {16'd0, latched}, 32'h001F);
    repeat (40) step();
    chk("f1f_frames", frames - b_frames, 32'd1);

    // Changes during a frame: original value sent, then one frame with 0x0007.
    b_frames = frames;
    led = 16'h0001;
    step();
    repeat (20) step();
    led = 16'h0003;
    repeat (20) step();
    led = 16'h0007;
    wait_idle("chg_a");
    chk("chg_first_word", {16'd0, latched}, 32'h0001);
    step();
    chk("chg_restart_busy", {31'd0, busy}, 32'd1);
    wait_idle("chg_b");
    chk("chg_second_word", {16'd0, latched}, 32'h0007);
    repeat (40) step();
    chk("chg_frames", frames - b_frames, 32'd2);

    // A->B->A inside one frame gives no second frame.
    b_frames = frames;
    led = 16'hA5A5;
    step();
    repeat (10) step();
    led = 16'h1234;
    repeat (10) step();
    led = 16'hA5A5;
    wait_idle("aba");
    repeat (30) step();
    chk("aba_frames", frames - b_frames, 32'd1);
    chk("aba_word", {16'd0, latched}, 32'hA5A5);

    // Narrow fast instance: WIDTH=4, CLK_DIV=1.
    b_rises_s = rises_s; b_frames_s = frames_s; b_lat_s = lat_cyc_s;
    b_busy_s = busy_cyc_s; b_hi_s = hi_cyc_s;
    led_s = 4'b1010;
    repeat (20) step();
    chk("s_rises", rises_s - b_rises_s, 32'd4);
    chk("s_high_cycles", hi_cyc_s - b_hi_s, 32'd4);
    chk("s_busy_cycles", busy_cyc_s - b_busy_s, 32'd9);
    chk("s_latch_cycles", lat_cyc_s - b_lat_s, 32'd1);
    chk("s_frames", frames_s - b_frames_s, 32'd1);
    chk("s_word", {28'd0, latched_s}, 32'hA);
    chk("s_stable", stab_err_s, 32'd0);

    // Reset at the 8th sclk rise of an all-ones frame.
    b_frames = frames;
    b_rises = rises;
    led = 16'hFFFF;
    step();
    chk("rst_mid_first_sdata", {31'd0, sdata}, 32'd1);
    begin
      int n = 0;
      while ((rises - b_rises) < 8 && n < 400) begin
        step();
        n++;
      end
    end
    chk("rst_mid_rises", rises - b_rises, 32'd8);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {28'd0, sclk, sdata, latch, busy}, 32'd0);
`ifdef LED_SER_OE_EN
    chk("rst_mid_oe_n", {31'd0, oe_n}, 32'd1);
`endif
    led = 16'h00C3;
    repeat (3) step();
    chk("rst_mid_no_latch", frames - b_frames, 32'd0);
    rst_n = 1'b1;
    step();
    chk("reinit_busy", {31'd0, busy}, 32'd1);
    wait_idle("reinit");
    chk("reinit_word", {16'd0, latched}, 32'h00C3);
    chk("reinit_frames", frames - b_frames, 32'd1);
`ifdef LED_SER_OE_EN
    chk("reinit_oe_n", {31'd0, oe_n}, 32'd0);
`endif
    chk("stable_main", stab_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
